// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: the cache line and its geometry.
package lc3b_types;

    typedef logic [127:0] lc3b_line;

    localparam int LC3B_LINE_WORDS  = 8;
    localparam int LC3B_OFFSET_BITS = 4;

endpackage

// File: rtl/pmem_line_buffer.sv
// One cache line held as a register, addressable as whole line or by beat index.
module pmem_line_buffer #(
    parameter int WORD_WIDTH = 16,
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             load,
    input  logic [WORD_WIDTH*LINE_WORDS-1:0] load_line,
    input  logic                             word_we,
    input  logic [IDX_W-1:0]                 word_idx,
    input  logic [WORD_WIDTH-1:0]            word_in,
    input  logic [IDX_W-1:0]                 rd_idx,
    output logic [WORD_WIDTH-1:0]            word_out,
    output logic [WORD_WIDTH*LINE_WORDS-1:0] line_out
);

    logic [WORD_WIDTH*LINE_WORDS-1:0] line_q;

    // A full-line load wins over a single-beat write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= load_line;
        end else if (word_we) begin
            line_q[word_idx*WORD_WIDTH +: WORD_WIDTH] <= word_in;
        end
    end

    assign word_out = line_q[rd_idx*WORD_WIDTH +: WORD_WIDTH];
    assign line_out = line_q;

endmodule

// File: rtl/pmem_line_adapter.sv
// Cache-side line responder that splits each 128-bit line transfer into
// LINE_WORDS sequential word accesses on the narrow word-memory port.
module pmem_line_adapter
    import lc3b_types::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int LINE_WORDS = LC3B_LINE_WORDS,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  lc3b_line              pmem_wdata,
    output lc3b_line              pmem_rdata,
    output logic                  pmem_resp,
    output logic                  wmem_read,
    output logic                  wmem_write,
    output logic [ADDR_WIDTH-1:0] wmem_address,
    output logic [WORD_WIDTH-1:0] wmem_wdata,
    input  logic [WORD_WIDTH-1:0] wmem_rdata,
    input  logic                  wmem_resp
);

    localparam int CNT_W      = $clog2(LINE_WORDS);
    localparam int BYTE_SHIFT = $clog2(WORD_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] beat_offset;
    logic                  capture;
    logic                  in_burst;
    logic [WORD_WIDTH-1:0] wr_word;
    logic [WORD_WIDTH-1:0] rd_word_unused;
    lc3b_line              wr_line_unused;
    logic [LC3B_OFFSET_BITS-1:0] addr_low_unused;

    assign capture         = (state_q == IDLE) && (pmem_read || pmem_write);
    assign in_burst        = (state_q == RD_BURST) || (state_q == WR_BURST);
    assign beat_offset     = ADDR_WIDTH'(cnt_q) << BYTE_SHIFT;
    assign addr_low_unused = pmem_address[LC3B_OFFSET_BITS-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The counter wraps back to zero after the last beat; it is reloaded on capture anyway.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            base_q <= '0;
        end else if (capture) begin
            cnt_q  <= '0;
            base_q <= {pmem_address[ADDR_WIDTH-1:LC3B_OFFSET_BITS], {LC3B_OFFSET_BITS{1'b0}}};
        end else if (in_burst && wmem_resp) begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pmem_write) begin
                    state_d = WR_BURST;
                end else if (pmem_read) begin
                    state_d = RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (wmem_resp && (cnt_q == LAST_BEAT)) begin
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pmem_resp    = (state_q == RESP);
        wmem_read    = (state_q == RD_BURST);
        wmem_write   = (state_q == WR_BURST);
        wmem_address = '0;
        wmem_wdata   = '0;
        if (in_burst) begin
            wmem_address = base_q + beat_offset;
            wmem_wdata   = wr_word;
        end
    end

    // Separate buffers so a write burst never disturbs the last read line.
    pmem_line_buffer #(
        .WORD_WIDTH (WORD_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_rd_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (1'b0),
        .load_line ('0),
        .word_we   ((state_q == RD_BURST) && wmem_resp),
        .word_idx  (cnt_q),
        .word_in   (wmem_rdata),
        .rd_idx    (cnt_q),
        .word_out  (rd_word_unused),
        .line_out  (pmem_rdata)
    );

    pmem_line_buffer #(
        .WORD_WIDTH (WORD_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_wr_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (capture && pmem_write),
        .load_line (pmem_wdata),
        .word_we   (1'b0),
        .word_idx  ('0),
        .word_in   ('0),
        .rd_idx    (cnt_q),
        .word_out  (wr_word),
        .line_out  (wr_line_unused)
    );

endmodule
